// File: rtl/memory_pkg.sv
// Shared types and access-size encodings for the KCP53K MEM stage.
// xrs_rwe: bit 2 = sign-extend, bits [1:0] = log2(access size in bytes).
package memory_pkg;

  typedef enum logic {StIdle, StBus} state_e;

  localparam logic [2:0] XRS_RWE_U8  = 3'b000;
  localparam logic [2:0] XRS_RWE_U16 = 3'b001;
  localparam logic [2:0] XRS_RWE_U32 = 3'b010;
  localparam logic [2:0] XRS_RWE_S8  = 3'b100;
  localparam logic [2:0] XRS_RWE_S16 = 3'b101;
  localparam logic [2:0] XRS_RWE_S32 = 3'b110;
  localparam logic [2:0] XRS_RWE_S64 = 3'b111;

  function automatic logic xrs_signed(logic [2:0] rwe);
    return rwe[2];
  endfunction

  // True when the byte offset is not a multiple of the access size.
  function automatic logic misaligned(logic [2:0] rwe, logic [2:0] off);
    logic [2:0] mask;
    case (rwe[1:0])
      2'd0:    mask = 3'b000;
      2'd1:    mask = 3'b001;
      2'd2:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return |(off & mask);
  endfunction

endpackage

// File: rtl/memory_lane.sv
// Byte-lane steering: store select/replication and load extraction/extension.
module memory_lane
  import memory_pkg::*;
(
  input  logic [2:0]  rwe,
  input  logic [2:0]  off,
  input  logic [63:0] st_dat,
  input  logic [63:0] bus_dat,
  output logic [7:0]  sel,
  output logic [63:0] wr_dat,
  output logic [63:0] ld_dat
);

  logic [63:0] sh;
  logic        sx;

  always_comb begin
    sh     = bus_dat >> {off, 3'b000};
    sx     = xrs_signed(rwe);
    sel    = '0;
    wr_dat = '0;
    ld_dat = '0;
    case (rwe[1:0])
      2'd0: begin
        sel    = 8'h01 << off;
        wr_dat = {8{st_dat[7:0]}};
        ld_dat = {{56{sx & sh[7]}}, sh[7:0]};
      end
      2'd1: begin
        sel    = 8'h03 << off;
        wr_dat = {4{st_dat[15:0]}};
        ld_dat = {{48{sx & sh[15]}}, sh[15:0]};
      end
      2'd2: begin
        sel    = 8'h0F << off;
        wr_dat = {2{st_dat[31:0]}};
        ld_dat = {{32{sx & sh[31]}}, sh[31:0]};
      end
      default: begin
        sel    = 8'hFF;
        wr_dat = st_dat;
        ld_dat = sh;
      end
    endcase
  end

endmodule

// File: rtl/memory.sv
// KCP53K MEM stage: passes ALU results through or runs one bus cycle per load/store.
// Results are registered; bus signals are decoded from state so reset drops them at once.
module memory
  import memory_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        valid_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] dat_i,
  input  logic [4:0]  rd_i,
  input  logic        we_i,
  input  logic        mem_i,
  input  logic        nomem_i,
  input  logic [2:0]  xrs_rwe_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [63:0] q_o,
  output logic [4:0]  rd_o,
  output logic        misalign_o,
  output logic        buserr_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [63:0] wb_adr_o,
  output logic [7:0]  wb_sel_o,
  output logic [63:0] wb_dat_o,
  input  logic [63:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  state_e      state_q, state_d;
  logic [63:0] addr_q, dat_q;
  logic [4:0]  rd_q;
  logic [2:0]  rwe_q;
  logic        we_q;
  logic [7:0]  cnt_q, cnt_d;

  logic        valid_d, mis_d, berr_d;
  logic [63:0] q_d;
  logic [4:0]  rd_d;

  logic        in_bus, timeout, latch_en;
  logic [7:0]  sel;
  logic [63:0] wr_dat, ld_dat;

  assign in_bus  = (state_q == StBus);
  assign timeout = (cnt_q == 8'(TIMEOUT - 1));
  assign busy_o  = in_bus & ~(wb_ack_i | wb_err_i | timeout);
  assign latch_en = (state_q == StIdle) & valid_i & mem_i & ~misaligned(xrs_rwe_i, addr_i[2:0]);

  memory_lane u_lane (
    .rwe     (rwe_q),
    .off     (addr_q[2:0]),
    .st_dat  (dat_q),
    .bus_dat (wb_dat_i),
    .sel     (sel),
    .wr_dat  (wr_dat),
    .ld_dat  (ld_dat)
  );

  assign wb_cyc_o = in_bus;
  assign wb_stb_o = in_bus;
  assign wb_we_o  = in_bus & we_q;
  assign wb_adr_o = in_bus ? {addr_q[63:3], 3'b000} : '0;
  assign wb_sel_o = in_bus ? sel : '0;
  assign wb_dat_o = in_bus ? wr_dat : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    valid_d = 1'b0;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    q_d     = '0;
    rd_d    = '0;
    unique case (state_q)
      StIdle: begin
        if (valid_i && mem_i) begin
          if (misaligned(xrs_rwe_i, addr_i[2:0])) begin
            valid_d = 1'b1;
            mis_d   = 1'b1;
          end else begin
            state_d = StBus;
          end
        end else if (valid_i && nomem_i) begin
          valid_d = 1'b1;
          q_d     = addr_i;
          rd_d    = rd_i;
        end
      end
      StBus: begin
        cnt_d = cnt_q + 8'd1;
        // Error outranks a simultaneous ack.
        if (wb_err_i || timeout) begin
          state_d = StIdle;
          valid_d = 1'b1;
          berr_d  = 1'b1;
        end else if (wb_ack_i) begin
          state_d = StIdle;
          valid_d = 1'b1;
          if (!we_q) begin
            q_d  = ld_dat;
            rd_d = rd_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      dat_q      <= '0;
      rd_q       <= '0;
      rwe_q      <= '0;
      we_q       <= 1'b0;
      valid_o    <= 1'b0;
      misalign_o <= 1'b0;
      buserr_o   <= 1'b0;
      q_o        <= '0;
      rd_o       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_o    <= valid_d;
      misalign_o <= mis_d;
      buserr_o   <= berr_d;
      q_o        <= q_d;
      rd_o       <= rd_d;
      if (latch_en) begin
        addr_q <= addr_i;
        dat_q  <= dat_i;
        rd_q   <= rd_i;
        rwe_q  <= xrs_rwe_i;
        we_q   <= we_i;
      end
    end
  end

endmodule

// File: tb/tb_memory.sv
// Directed bench for the MEM stage; retired results checked against a scoreboard queue.
module tb_memory;
  import memory_pkg::*;

  localparam int unsigned TO = 16;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        valid_i, we_i, mem_i, nomem_i;
  logic [63:0] addr_i, dat_i, wb_dat_i;
  logic [4:0]  rd_i;
  logic [2:0]  xrs_rwe_i;
  logic        wb_ack_i, wb_err_i;
  logic        busy_o, valid_o, misalign_o, buserr_o;
  logic [63:0] q_o, wb_adr_o, wb_dat_o;
  logic [4:0]  rd_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [7:0]  wb_sel_o;

  typedef struct packed {
    logic [63:0] q;
    logic [4:0]  rd;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  memory #(.TIMEOUT(TO)) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .valid_i    (valid_i),
    .addr_i     (addr_i),
    .dat_i      (dat_i),
    .rd_i       (rd_i),
    .we_i       (we_i),
    .mem_i      (mem_i),
    .nomem_i    (nomem_i),
    .xrs_rwe_i  (xrs_rwe_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .q_o        (q_o),
    .rd_o       (rd_o),
    .misalign_o (misalign_o),
    .buserr_o   (buserr_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_sel_o   (wb_sel_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic m, input logic nm, input logic w,
                       input logic [2:0] rwe, input logic [63:0] a, input logic [63:0] d,
                       input logic [4:0] r);
    valid_i = v; mem_i = m; nomem_i = nm; we_i = w;
    xrs_rwe_i = rwe; addr_i = a; dat_i = d; rd_i = r;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 64'h0, 5'd0);
  endtask

  // Waits (bounded) for a retired result and compares it with the oldest expectation.
  task automatic retire(input string tag);
    exp_t e;
    int   n;
    n = 0;
    while (!valid_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, ".valid"}, valid_o, 1'b1);
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s.sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".q"}, q_o, e.q);
      check({tag, ".rd"}, rd_o, e.rd);
      check({tag, ".mis"}, misalign_o, e.mis);
      check({tag, ".berr"}, buserr_o, e.berr);
    end
  endtask

  // Issue a bus access at a negedge, hold `waits` busy cycles, then respond.
  task automatic bus_op(input string tag, input logic w, input logic nm, input logic [2:0] rwe,
                        input logic [63:0] a, input logic [63:0] d, input logic [4:0] r,
                        input int waits, input logic ack, input logic err,
                        input logic [63:0] rdata, input logic [7:0] e_sel,
                        input logic [63:0] e_wdat);
    drive(1'b1, 1'b1, nm, w, rwe, a, d, r);
    @(negedge clk_i);
    idle_inputs();
    check({tag, ".cyc"}, wb_cyc_o, 1'b1);
    check({tag, ".stb"}, wb_stb_o, 1'b1);
    check({tag, ".we"}, wb_we_o, w);
    check({tag, ".adr"}, wb_adr_o, {a[63:3], 3'b000});
    check({tag, ".sel"}, wb_sel_o, e_sel);
    if (w) check({tag, ".wdat"}, wb_dat_o, e_wdat);
    check({tag, ".rd_bus"}, rd_o, 5'd0);
    check({tag, ".valid_bus"}, valid_o, 1'b0);
    for (int i = 0; i < waits; i++) begin
      check({tag, ".busy"}, busy_o, 1'b1);
      @(negedge clk_i);
    end
    wb_ack_i = ack; wb_err_i = err; wb_dat_i = rdata;
    #1;
    check({tag, ".busy_end"}, busy_o, 1'b0);
    @(negedge clk_i);
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = '0;
    check({tag, ".cyc_end"}, wb_cyc_o, 1'b0);
    retire(tag);
  endtask

  initial begin
    int cnt;
    reset_ni = 1'b0;
    idle_inputs();
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst.valid", valid_o, 1'b0);
    check("rst.q", q_o, 64'h0);
    check("rst.rd", rd_o, 5'd0);
    check("rst.cyc", wb_cyc_o, 1'b0);
    check("rst.busy", busy_o, 1'b0);
    check("rst.pulses", {misalign_o, buserr_o}, 2'b00);
    reset_ni = 1'b1;
    @(negedge clk_i);

    // 1: ALU pass-through, latency one.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 64'hFACE0BADC0FFEE00, 64'h0, 5'd3);
    sb.push_back('{q: 64'hFACE0BADC0FFEE00, rd: 5'd3, mis: 1'b0, berr: 1'b0});
    @(negedge clk_i);
    idle_inputs();
    check("nomem.cyc", wb_cyc_o, 1'b0);
    retire("nomem");
    @(negedge clk_i);
    check("bubble.valid", valid_o, 1'b0);
    check("bubble.q", q_o, 64'h0);
    check("bubble.rd", rd_o, 5'd0);

    // 2: byte store, ack after two wait cycles.
    sb.push_back('{q: 64'h0, rd: 5'd0, mis: 1'b0, berr: 1'b0});
    bus_op("sb", 1'b1, 1'b0, XRS_RWE_S8, 64'h1003, 64'hDEADBEEFFEEDFACE, 5'd4, 2, 1'b1, 1'b0,
           64'h0, 8'h08, 64'hCECECECECECECECE);
    @(negedge clk_i);

    // Halfword store lane replication.
    sb.push_back('{q: 64'h0, rd: 5'd0, mis: 1'b0, berr: 1'b0});
    bus_op("sh", 1'b1, 1'b0, XRS_RWE_S16, 64'h100A, 64'h0000000000001234, 5'd5, 0, 1'b1, 1'b0,
           64'h0, 8'h0C, 64'h1234123412341234);
    @(negedge clk_i);

    // 3: signed and unsigned byte loads.
    sb.push_back('{q: 64'hFFFFFFFFFFFFFF80, rd: 5'd7, mis: 1'b0, berr: 1'b0});
    bus_op("lb", 1'b0, 1'b0, XRS_RWE_S8, 64'h1005, 64'h0, 5'd7, 1, 1'b1, 1'b0,
           64'h0000800000000000, 8'h20, 64'h0);
    @(negedge clk_i);
    sb.push_back('{q: 64'h0000000000000080, rd: 5'd7, mis: 1'b0, berr: 1'b0});
    bus_op("lbu", 1'b0, 1'b0, XRS_RWE_U8, 64'h1005, 64'h0, 5'd7, 0, 1'b1, 1'b0,
           64'h0000800000000000, 8'h20, 64'h0);
    @(negedge clk_i);
    sb.push_back('{q: 64'hFFFFFFFF89ABCDEF, rd: 5'd10, mis: 1'b0, berr: 1'b0});
    bus_op("lw", 1'b0, 1'b0, XRS_RWE_S32, 64'h1004, 64'h0, 5'd10, 0, 1'b1, 1'b0,
           64'h89ABCDEF00000000, 8'hF0, 64'h0);
    @(negedge clk_i);
    sb.push_back('{q: 64'h00000000000089AB, rd: 5'd11, mis: 1'b0, berr: 1'b0});
    bus_op("lhu", 1'b0, 1'b0, XRS_RWE_U16, 64'h1006, 64'h0, 5'd11, 0, 1'b1, 1'b0,
           64'h89AB000000000000, 8'hC0, 64'h0);
    @(negedge clk_i);

    // 4: misaligned word store is dropped.
    drive(1'b1, 1'b1, 1'b0, 1'b1, XRS_RWE_S32, 64'h1002, 64'h55, 5'd6);
    sb.push_back('{q: 64'h0, rd: 5'd0, mis: 1'b1, berr: 1'b0});
    @(negedge clk_i);
    idle_inputs();
    check("sw_mis.cyc", wb_cyc_o, 1'b0);
    retire("sw_mis");
    @(negedge clk_i);
    check("sw_mis.pulse", misalign_o, 1'b0);

    // Doubleword load; mem wins over nomem when both are set.
    sb.push_back('{q: 64'h0123456789ABCDEF, rd: 5'd9, mis: 1'b0, berr: 1'b0});
    bus_op("ld", 1'b0, 1'b1, XRS_RWE_S64, 64'h1008, 64'h0, 5'd9, 1, 1'b1, 1'b0,
           64'h0123456789ABCDEF, 8'hFF, 64'h0);
    @(negedge clk_i);

    // 5: err and ack together -> bus error.
    sb.push_back('{q: 64'h0, rd: 5'd0, mis: 1'b0, berr: 1'b1});
    bus_op("ld_err", 1'b0, 1'b0, XRS_RWE_S64, 64'h1010, 64'h0, 5'd12, 0, 1'b1, 1'b1,
           64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0);
    @(negedge clk_i);

    // Unanswered load times out after TO bus cycles.
    drive(1'b1, 1'b1, 1'b0, 1'b0, XRS_RWE_S64, 64'h1018, 64'h0, 5'd13);
    sb.push_back('{q: 64'h0, rd: 5'd0, mis: 1'b0, berr: 1'b1});
    @(negedge clk_i);
    idle_inputs();
    cnt = 0;
    while (wb_cyc_o && cnt < 4 * int'(TO)) begin
      cnt++;
      @(negedge clk_i);
    end
    check("timeout.cycles", 64'(cnt), 64'(TO));
    retire("timeout");
    @(negedge clk_i);

    // 6: asynchronous reset in the middle of a bus cycle.
    drive(1'b1, 1'b1, 1'b0, 1'b0, XRS_RWE_S64, 64'h1020, 64'h0, 5'd14);
    @(negedge clk_i);
    idle_inputs();
    check("arst.cyc_before", wb_cyc_o, 1'b1);
    #2 reset_ni = 1'b0;
    #1;
    check("arst.cyc", wb_cyc_o, 1'b0);
    check("arst.stb", wb_stb_o, 1'b0);
    check("arst.busy", busy_o, 1'b0);
    check("arst.outs", {valid_o, rd_o, misalign_o, buserr_o}, 8'h0);
    check("arst.bus", {wb_adr_o, wb_sel_o}, 72'h0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    check("arst.after", {valid_o, misalign_o, buserr_o, wb_cyc_o}, 4'h0);
    check("sb.drained", 64'(sb.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
